// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU encodings,
// FSM states and helpers that locate the fields inside an instruction word.
package datapath_defs;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_MOV  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_e;

  // Instruction layout MSB->LSB: opcode, rd, ra, rb, imm
  function automatic int rb_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int ra_lsb(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

  function automatic int rd_lsb(input int data_width, input int addr_width);
    return data_width + 2 * addr_width;
  endfunction

  function automatic int op_lsb(input int data_width, input int addr_width);
    return data_width + 3 * addr_width;
  endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction handshake plus all datapath control outputs of the sequencer.
interface datapath_controller_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int OP_WIDTH    = 3,
  parameter int COUNT_WIDTH = 8
);
  localparam int INSTR_WIDTH = OP_WIDTH + 3 * ADDR_WIDTH + DATA_WIDTH;

  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [ADDR_WIDTH-1:0]  rf_read_addr_a;
  logic [ADDR_WIDTH-1:0]  rf_read_addr_b;
  logic [1:0]             alu_op;
  logic                   alu_pass_a;
  logic [DATA_WIDTH-1:0]  imm_data;
  logic                   mux_control;
  logic                   rf_write_en;
  logic [ADDR_WIDTH-1:0]  rf_write_addr;
  logic                   done;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;

  modport master (
    output instr, instr_valid,
    input  instr_ready, rf_read_addr_a, rf_read_addr_b, alu_op, alu_pass_a,
           imm_data, mux_control, rf_write_en, rf_write_addr, done, halted,
           instr_count
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, rf_read_addr_a, rf_read_addr_b, alu_op, alu_pass_a,
           imm_data, mux_control, rf_write_en, rf_write_addr, done, halted,
           instr_count
  );

endinterface

// File: rtl/datapath_controller_decode.sv
// Combinational opcode decoder: next state after acceptance and the
// datapath controls that stay latched for the life of the instruction.
module instr_decode
  import datapath_defs::*;
#(
  parameter int OP_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output state_e              next_state,
  output alu_op_e             alu_op,
  output logic                alu_pass_a,
  output logic                mux_sel,
  output logic                write_en
);

  always_comb begin
    next_state = ST_EXEC;
    alu_op     = ALU_ADD;
    alu_pass_a = 1'b0;
    mux_sel    = 1'b1;
    write_en   = 1'b1;
    case (opcode)
      OP_WIDTH'(OP_NOP): begin
        next_state = ST_WRITE;
        write_en   = 1'b0;
      end
      OP_WIDTH'(OP_LDI): begin
        next_state = ST_WRITE;
        mux_sel    = 1'b0;
      end
      OP_WIDTH'(OP_ADD): alu_op = ALU_ADD;
      OP_WIDTH'(OP_SUB): alu_op = ALU_SUB;
      OP_WIDTH'(OP_AND): alu_op = ALU_AND;
      OP_WIDTH'(OP_OR):  alu_op = ALU_OR;
      OP_WIDTH'(OP_MOV): alu_pass_a = 1'b1;
      OP_WIDTH'(OP_HALT): begin
        next_state = ST_HALT;
        write_en   = 1'b0;
      end
      default: next_state = ST_EXEC;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer: accepts one instruction at a time, walks it through
// EXEC/WRITE, counts retirements and parks in HALT until reset.
module datapath_controller
  import datapath_defs::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int OP_WIDTH    = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  datapath_controller_if.slave bus
);

  localparam int RB_LSB = rb_lsb(DATA_WIDTH);
  localparam int RA_LSB = ra_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam int RD_LSB = rd_lsb(DATA_WIDTH, ADDR_WIDTH);
  localparam int OP_LSB = op_lsb(DATA_WIDTH, ADDR_WIDTH);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_WIDTH-1:0]  imm_q, imm_d;
  alu_op_e                alu_op_q, alu_op_d;
  logic                   pass_q, pass_d;
  logic                   mux_q, mux_d;
  logic                   wr_q, wr_d;
  logic                   halt_seen_q, halt_seen_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  state_e                 dec_next;
  alu_op_e                dec_alu_op;
  logic                   dec_pass, dec_mux, dec_wr;
  logic                   ready, accept, done;

  instr_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .opcode     (bus.instr[OP_LSB +: OP_WIDTH]),
    .next_state (dec_next),
    .alu_op     (dec_alu_op),
    .alu_pass_a (dec_pass),
    .mux_sel    (dec_mux),
    .write_en   (dec_wr)
  );

  // Decoded controls are captured at acceptance so they stay stable through WRITE
  always_comb begin
    ready       = !rst && (state_q == ST_IDLE || state_q == ST_WRITE);
    accept      = ready && bus.instr_valid;
    done        = (state_q == ST_WRITE) || (state_q == ST_HALT && !halt_seen_q);
    state_d     = state_q;
    rd_d        = rd_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    pass_d      = pass_q;
    mux_d       = mux_q;
    wr_d        = wr_q;
    halt_seen_d = halt_seen_q || (state_q == ST_HALT);
    count_d     = done ? count_q + COUNT_WIDTH'(1) : count_q;

    case (state_q)
      ST_IDLE:  if (accept) state_d = dec_next;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = accept ? dec_next : ST_IDLE;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      rd_d     = bus.instr[RD_LSB +: ADDR_WIDTH];
      ra_d     = bus.instr[RA_LSB +: ADDR_WIDTH];
      rb_d     = bus.instr[RB_LSB +: ADDR_WIDTH];
      imm_d    = bus.instr[0 +: DATA_WIDTH];
      alu_op_d = dec_alu_op;
      pass_d   = dec_pass;
      mux_d    = dec_mux;
      wr_d     = dec_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= ALU_ADD;
      pass_q      <= 1'b0;
      mux_q       <= 1'b0;
      wr_q        <= 1'b0;
      halt_seen_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      pass_q      <= pass_d;
      mux_q       <= mux_d;
      wr_q        <= wr_d;
      halt_seen_q <= halt_seen_d;
      count_q     <= count_d;
    end
  end

  assign bus.instr_ready    = ready;
  assign bus.rf_read_addr_a = ra_q;
  assign bus.rf_read_addr_b = rb_q;
  assign bus.alu_op         = alu_op_q;
  assign bus.alu_pass_a     = pass_q;
  assign bus.imm_data       = imm_q;
  assign bus.mux_control    = mux_q;
  assign bus.rf_write_en    = (state_q == ST_WRITE) && wr_q;
  assign bus.rf_write_addr  = rd_q;
  assign bus.done           = done;
  assign bus.halted         = (state_q == ST_HALT);
  assign bus.instr_count    = count_q;

endmodule
